coeff_bank_scheduler: RTL and testbench
=======================================

// Module: coeff_bank_scheduler
// PURPOSE
//   Double-buffered coefficient controller for the 5x5 2D FIR. Register-side writes land in a
//   shadow bank; a commit request arms a swap that copies shadow->active only at the next rising
//   edge of vs_i, so the FIR never sees a kernel changed mid-frame. Sits between the coefficient
//   register interface and the cascade FIR coefficient inputs, in the video pixel clock domain.
// PARAMETERS
//   COEFF_W     16       width of one signed coefficient
//   NUM_COEFF   25       kernel taps, index k = row*5 + col (k=0 -> coeff00, k=24 -> coeff44)
//   CENTER_RST  16'h0100 reset value of tap 12 (identity kernel); all other taps reset to 0
//   FCNT_W      16       width of frame counter
// PORTS
//   clk          in   1                 pixel clock (the only clock)
//   rst          in   1                 reset, asynchronous assert, active-low
//   wr_valid     in   1                 coefficient write request
//   wr_ready     out  1                 write accepted when wr_valid & wr_ready
//   wr_addr      in   5                 tap index 0..24
//   wr_data      in   COEFF_W           signed coefficient value
//   commit_i     in   1                 one-cycle request: arm shadow->active swap
//   abort_i      in   1                 cancel an armed swap
//   vs_i         in   1                 vertical sync from video input
//   coeff_o      out  NUM_COEFF*COEFF_W active bank, tap k at [k*COEFF_W +: COEFF_W]
//   pending_o    out  1                 1 while a swap is armed
//   commit_done  out  1                 one-cycle pulse: active bank just updated
//   addr_err     out  1                 one-cycle pulse: accepted write had wr_addr > 24
//   frame_cnt    out  FCNT_W            count of vs_i rising edges, wraps
// BEHAVIOUR
//   Reset (rst=0, async): both banks = identity (tap12=CENTER_RST, rest 0); state IDLE;
//     wr_ready=1, pending_o=0, commit_done=0, addr_err=0, frame_cnt=0, vs_q=0.
//   vs_rise = vs_i & ~vs_q; vs_q is vs_i registered each cycle.
//   FSM: IDLE, ARMED, SWAP.
//     IDLE : wr_ready=1. commit_i -> ARMED. abort_i ignored.
//     ARMED: wr_ready=0, pending_o=1. abort_i -> IDLE (shadow kept, active unchanged).
//            vs_rise (and no abort_i) -> SWAP; active<=shadow on this clock edge.
//            abort_i and vs_rise same cycle: abort wins, no swap.
//            commit_i while ARMED ignored.
//     SWAP : one cycle; wr_ready=0, pending_o=0, commit_done=1; -> IDLE unconditionally.
//   Swap latency: coeff_o shows new kernel in the cycle after the vs_rise cycle, coinciding
//     with commit_done=1; all 25 taps change in that same cycle (atomic).
//   Writes: accepted only in IDLE; shadow[wr_addr] updated on the accepting edge, visible to a
//     swap from the next cycle. wr_addr 25..31: accepted (no stall), data dropped, addr_err
//     pulses the following cycle. Active bank is never written directly.
//   Write and commit_i in the same IDLE cycle: write is accepted and is included in the swap.
//   frame_cnt increments on every vs_rise in any state; FCNT_W'hFFFF -> 0 wraps silently.
//   vs_i held high across commit_i: no swap until vs_i falls and rises again.
//   Reset mid-ARMED or mid-SWAP: return to reset state; no commit_done pulse issued.
//   coeff_o, pending_o, commit_done, addr_err are registered (no combinational input paths).
// TESTING
//   Reset: release rst -> coeff_o tap12=16'h0100, taps 0-11,13-24=0; wr_ready=1; frame_cnt=0.
//   Full load: write taps k=0..24 with data k+1, commit_i, vs_i 0->1 at cycle N -> coeff_o
//     unchanged through N, tap k = k+1 and commit_done=1 at N+1 only, pending_o 1 until N.
//   Stall: in ARMED drive wr_valid, addr 3, data 16'h7FFF -> wr_ready=0, shadow unchanged;
//     after swap, wr_ready=1 and write then accepted.
//   Bad addr: write addr 25 data 16'h1234 -> addr_err 1 cycle, no tap changes after commit.
//   Same-cycle write+commit (addr 12, 16'hFF00) then vs_rise -> tap12 = 16'hFF00 after swap;
//     abort_i coincident with vs_rise -> no swap, pending_o=0, coeff_o unchanged.
//   Reset while ARMED, and frame_cnt preset to 16'hFFFF + one vs_rise -> identity, IDLE; 16'h0000.

Source files
------------

// File: rtl/coeff_bank_scheduler.sv
// coeff_bank_scheduler: double-buffered 5x5 FIR coefficient bank.
// Shadow writes reach the active bank atomically on the first vs_i rise after a commit.
module coeff_bank_scheduler #(
   parameter int                 COEFF_W    = 16,
   parameter int                 NUM_COEFF  = 25,
   parameter logic [COEFF_W-1:0] CENTER_RST = 16'h0100,
   parameter int                 FCNT_W     = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wr_valid,
   output logic                           wr_ready,
   input  logic [4:0]                     wr_addr,
   input  logic [COEFF_W-1:0]             wr_data,
   input  logic                           commit_i,
   input  logic                           abort_i,
   input  logic                           vs_i,
   output logic [NUM_COEFF*COEFF_W-1:0]   coeff_o,
   output logic                           pending_o,
   output logic                           commit_done,
   output logic                           addr_err,
   output logic [FCNT_W-1:0]              frame_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_SWAP  = 2'd2;
   localparam int         CENTER   = NUM_COEFF / 2;

   logic [1:0]        state_q, state_d;
   logic              vs_q;
   logic              vs_rise;
   logic              wr_fire;
   logic              addr_ok;
   logic              swap_en;
   logic              addr_err_q;
   logic [FCNT_W-1:0] frame_cnt_q;

   assign vs_rise  = vs_i & ~vs_q;
   assign wr_ready = (state_q == ST_IDLE);
   assign wr_fire  = wr_valid & wr_ready;
   assign addr_ok  = (wr_addr < 5'(NUM_COEFF));

   // Abort has priority over a coincident frame start.
   always_comb begin
      state_d = state_q;
      swap_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (commit_i) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (vs_rise) begin
               state_d = ST_SWAP;
               swap_en = 1'b1;
            end
         end
         ST_SWAP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         vs_q        <= 1'b0;
         addr_err_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         vs_q       <= vs_i;
         addr_err_q <= wr_fire & ~addr_ok;
         if (vs_rise) frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_COEFF; gi++) begin : g_tap
         localparam logic [COEFF_W-1:0] RST_VAL = (gi == CENTER) ? CENTER_RST : '0;
         logic [COEFF_W-1:0] shadow_q;
         logic [COEFF_W-1:0] active_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               shadow_q <= RST_VAL;
               active_q <= RST_VAL;
            end else begin
               if (wr_fire && addr_ok && (wr_addr == 5'(gi))) shadow_q <= wr_data;
               if (swap_en) active_q <= shadow_q;
            end
         end

         assign coeff_o[gi*COEFF_W +: COEFF_W] = active_q;
      end
   endgenerate

   assign pending_o   = (state_q == ST_ARMED);
   assign commit_done = (state_q == ST_SWAP);
   assign addr_err    = addr_err_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_coeff_bank_scheduler.sv
// Bench for coeff_bank_scheduler: directed stimulus, expected banks queued per swap.
// The frame counter is built 8 bits wide so its wrap is reachable in a few hundred cycles.
module tb_coeff_bank_scheduler;

   localparam int CW = 16;
   localparam int NC = 25;
   localparam int FW = 8;
   localparam int VW = NC * CW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, wr_valid, commit_i, abort_i, vs_i;
   logic [4:0]    wr_addr;
   logic [CW-1:0] wr_data;
   logic          wr_ready, pending_o, commit_done, addr_err;
   logic [VW-1:0] coeff_o;
   logic [FW-1:0] frame_cnt;

   int            vectors = 0;
   int            miscompares = 0;
   logic [VW-1:0] exp_q[$];
   bit            aerr_q[$];
   logic [CW-1:0] shadow_m [NC];
   logic [VW-1:0] active_m;
   int            fcnt_m = 0;

   coeff_bank_scheduler #(
      .COEFF_W   (CW),
      .NUM_COEFF (NC),
      .CENTER_RST(16'h0100),
      .FCNT_W    (FW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .commit_i   (commit_i),
      .abort_i    (abort_i),
      .vs_i       (vs_i),
      .coeff_o    (coeff_o),
      .pending_o  (pending_o),
      .commit_done(commit_done),
      .addr_err   (addr_err),
      .frame_cnt  (frame_cnt)
   );

   task automatic chkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chkt(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   function automatic logic [VW-1:0] ident();
      logic [VW-1:0] v;
      v = '0;
      v[12*CW +: CW] = 16'h0100;
      return v;
   endfunction

   function automatic logic [VW-1:0] pack_shadow();
      logic [VW-1:0] v;
      for (int k = 0; k < NC; k++) v[k*CW +: CW] = shadow_m[k];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vs(input logic v);
      if (v && !vs_i) fcnt_m++;
      vs_i = v;
   endtask

   task automatic wr(input int a, input logic [CW-1:0] d);
      wr_valid = 1'b1;
      wr_addr  = a[4:0];
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
      if (a < NC) shadow_m[a] = d;
   endtask

   task automatic commit();
      commit_i = 1'b1;
      tick();
      commit_i = 1'b0;
      @(negedge clk);
      chk1("armed_pending", pending_o, 1'b1);
      chk1("armed_wr_ready", wr_ready, 1'b0);
      tick();
   endtask

   // Enter with the block ARMED and vs_i low; leaves it IDLE with the new bank live.
   task automatic do_swap();
      set_vs(1'b1);
      exp_q.push_back(pack_shadow());
      @(negedge clk);
      chkv("pre_swap_coeff", coeff_o, active_m);
      chk1("pre_swap_pending", pending_o, 1'b1);
      tick();
      set_vs(1'b0);
      active_m = pack_shadow();
      @(negedge clk);
      chkt("swap_frame_cnt", 16'(frame_cnt), 16'(fcnt_m[FW-1:0]));
      chk1("swap_wr_ready", wr_ready, 1'b0);
      tick();
      @(negedge clk);
      chk1("post_swap_done", commit_done, 1'b0);
      chk1("post_swap_wr_ready", wr_ready, 1'b1);
      tick();
   endtask

   // Monitor: every commit_done / addr_err pulse must match a queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && commit_done === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk1("unexpected_commit_done", commit_done, 1'b0);
            end else begin
               chkv("swap_coeff", coeff_o, exp_q.pop_front());
               chk1("swap_pending_low", pending_o, 1'b0);
            end
         end
         if (rst === 1'b1 && addr_err === 1'b1) begin
            if (aerr_q.size() == 0) chk1("unexpected_addr_err", addr_err, 1'b0);
            else                    chk1("addr_err_pulse", addr_err, aerr_q.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      commit_i = 1'b0; abort_i = 1'b0; vs_i = 1'b0;
      for (int k = 0; k < NC; k++) shadow_m[k] = '0;
      shadow_m[12] = 16'h0100;
      active_m = ident();

      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chkv("reset_coeff", coeff_o, ident());
      chk1("reset_wr_ready", wr_ready, 1'b1);
      chk1("reset_pending", pending_o, 1'b0);
      chk1("reset_commit_done", commit_done, 1'b0);
      chk1("reset_addr_err", addr_err, 1'b0);
      chkt("reset_frame_cnt", 16'(frame_cnt), 16'h0000);
      tick();

      // Full load: tap k = k+1
      for (int k = 0; k < NC; k++) wr(k, 16'(k + 1));
      commit();
      do_swap();
      chkt("full_tap0", coeff_o[0*CW +: CW], 16'd1);
      chkt("full_tap12", coeff_o[12*CW +: CW], 16'd13);
      chkt("full_tap24", coeff_o[24*CW +: CW], 16'd25);

      // Stall: write held while ARMED, accepted once back in IDLE
      commit_i = 1'b1; tick(); commit_i = 1'b0;
      wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 16'h7FFF;
      @(negedge clk);
      chk1("stall_wr_ready", wr_ready, 1'b0);
      tick(); tick();
      set_vs(1'b1);
      exp_q.push_back(pack_shadow());
      tick();
      set_vs(1'b0);
      active_m = pack_shadow();
      @(negedge clk);
      chk1("stall_swap_wr_ready", wr_ready, 1'b0);
      tick();
      @(negedge clk);
      chk1("stall_resume_wr_ready", wr_ready, 1'b1);
      tick();
      wr_valid = 1'b0;
      shadow_m[3] = 16'h7FFF;
      chkt("stall_tap3_kept", coeff_o[3*CW +: CW], 16'd4);
      commit();
      do_swap();
      chkt("stall_tap3_new", coeff_o[3*CW +: CW], 16'h7FFF);

      // Bad address: accepted, dropped, flagged
      wr_valid = 1'b1; wr_addr = 5'd25; wr_data = 16'h1234;
      aerr_q.push_back(1'b1);
      tick();
      wr_valid = 1'b0;
      @(negedge clk);
      chk1("bad_addr_err_high", addr_err, 1'b1);
      tick();
      @(negedge clk);
      chk1("bad_addr_err_low", addr_err, 1'b0);
      tick();
      commit();
      do_swap();
      chkt("bad_addr_tap12", coeff_o[12*CW +: CW], 16'd13);
      chkt("bad_addr_tap24", coeff_o[24*CW +: CW], 16'd25);

      // Write and commit in the same cycle
      wr_valid = 1'b1; wr_addr = 5'd12; wr_data = 16'hFF00; commit_i = 1'b1;
      tick();
      wr_valid = 1'b0; commit_i = 1'b0;
      shadow_m[12] = 16'hFF00;
      @(negedge clk);
      chk1("wc_pending", pending_o, 1'b1);
      tick();
      do_swap();
      chkt("wc_tap12", coeff_o[12*CW +: CW], 16'hFF00);

      // Abort coincident with vs rise: no swap
      wr(0, 16'hAAAA);
      commit();
      abort_i = 1'b1;
      set_vs(1'b1);
      tick();
      abort_i = 1'b0;
      set_vs(1'b0);
      @(negedge clk);
      chk1("abort_pending", pending_o, 1'b0);
      chk1("abort_wr_ready", wr_ready, 1'b1);
      chkv("abort_coeff", coeff_o, active_m);
      chkt("abort_frame_cnt", 16'(frame_cnt), 16'(fcnt_m[FW-1:0]));
      tick();

      // vs held high across commit: swap waits for a fresh rise (shadow kept from abort)
      set_vs(1'b1);
      tick(); tick();
      commit_i = 1'b1; tick(); commit_i = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk1("vs_held_pending", pending_o, 1'b1);
      chkv("vs_held_coeff", coeff_o, active_m);
      tick();
      set_vs(1'b0);
      tick();
      do_swap();
      chkt("vs_held_tap0", coeff_o[0*CW +: CW], 16'hAAAA);

      // Reset while ARMED
      commit();
      rst = 1'b0;
      #2;
      chk1("rst_armed_pending", pending_o, 1'b0);
      chk1("rst_armed_wr_ready", wr_ready, 1'b1);
      chkv("rst_armed_coeff", coeff_o, ident());
      chkt("rst_armed_frame_cnt", 16'(frame_cnt), 16'h0000);
      for (int k = 0; k < NC; k++) shadow_m[k] = '0;
      shadow_m[12] = 16'h0100;
      active_m = ident();
      fcnt_m = 0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk1("rst_release_done", commit_done, 1'b0);
      tick(); tick();

      // Frame counter wrap
      for (int i = 0; i < 255; i++) begin
         set_vs(1'b1); tick();
         set_vs(1'b0); tick();
      end
      @(negedge clk);
      chkt("frame_cnt_max", 16'(frame_cnt), 16'h00FF);
      tick();
      set_vs(1'b1); tick(); set_vs(1'b0);
      @(negedge clk);
      chkt("frame_cnt_wrap", 16'(frame_cnt), 16'h0000);
      chkv("wrap_coeff", coeff_o, ident());
      chk1("wrap_pending", pending_o, 1'b0);
      tick();

      chkt("exp_q_drained", 16'(exp_q.size()), 16'd0);
      chkt("aerr_q_drained", 16'(aerr_q.size()), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
